// File: rtl/rv_pkg.sv
// Shared register-file types and constants for the integer pipeline.
// x0 is hardwired to zero; every writer must treat it as a sink.
package rv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  typedef logic [4:0]      reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

  localparam reg_addr_t REG_X0 = 5'd0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on commit.
// Updates on the next edge; set wins over clear for the same register; bit 0 never sets.
module reg_scoreboard
  import rv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set_vld,
  input  reg_addr_t        i_set_idx,
  input  logic             i_clr_vld,
  input  reg_addr_t        i_clr_idx,
  output logic [NREGS-1:0] o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic [NREGS-1:0] w_busy_nxt;

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (i_set_vld && (i_set_idx != REG_X0)) begin
      w_set_mask = NREGS'(1) << i_set_idx;
    end
    if (i_clr_vld) begin
      w_clr_mask = NREGS'(1) << i_clr_idx;
    end
    // Applying the set after the clear lets a re-issue survive a same-cycle commit.
    w_busy_nxt    = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/reg_wport_arbiter.sv
// Shares the register-file write port: core writeback first, secondary via valid/ready,
// zero added latency; a starved secondary force-stalls the core for one cycle.
module reg_wport_arbiter
  import rv_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_we,
  input  reg_addr_t        core_a3,
  input  xword_t           core_wd,
  input  logic             sec_valid,
  output logic             sec_ready,
  input  reg_addr_t        sec_a3,
  input  xword_t           sec_wd,
  input  logic             iss_valid,
  input  reg_addr_t        iss_rd,
  output logic             stall_core,
  output logic [NREGS-1:0] busy,
  output logic             rf_we,
  output reg_addr_t        rf_a3,
  output xword_t           rf_wd
);

  localparam logic [CNT_W-1:0] LP_MAX_WAIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_nxt;
  logic             w_core_use;
  logic             w_force;
  logic             w_hs;

  always_comb begin
    w_core_use = core_we && (core_a3 != REG_X0);
    w_force    = (r_wait_cnt == LP_MAX_WAIT) && sec_valid;
    sec_ready  = 1'b0;
    stall_core = 1'b0;
    rf_we      = 1'b0;
    rf_a3      = REG_X0;
    rf_wd      = '0;
    if (!reset) begin
      if (w_force) begin
        stall_core = 1'b1;
        sec_ready  = 1'b1;
        rf_we      = (sec_a3 != REG_X0);
        rf_a3      = sec_a3;
        rf_wd      = sec_wd;
      end else if (w_core_use) begin
        rf_we = 1'b1;
        rf_a3 = core_a3;
        rf_wd = core_wd;
      end else if (sec_valid) begin
        sec_ready = 1'b1;
        rf_we     = (sec_a3 != REG_X0);
        rf_a3     = sec_a3;
        rf_wd     = sec_wd;
      end
    end
  end

  assign w_hs = sec_valid && sec_ready;

  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!sec_valid || w_hs) begin
      w_wait_nxt = '0;
    end else if (r_wait_cnt != LP_MAX_WAIT) begin
      w_wait_nxt = r_wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_nxt;
    end
  end

  reg_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .i_set_vld (iss_valid),
    .i_set_idx (iss_rd),
    .i_clr_vld (w_hs),
    .i_clr_idx (sec_a3),
    .o_busy    (busy)
  );

endmodule

// File: doc/reg_wport_arbiter.md
Name: reg_wport_arbiter

Overview:
- Shares the register file's single write port (WE/A3/WD3) between two writers:
  - core writeback, which has fixed priority;
  - a secondary multicycle unit (e.g. divider or debug), which uses a valid/ready handshake.
- Guarantees forward progress for the secondary unit with a starvation counter that stalls the core for one cycle when needed.
- Keeps a 32-bit scoreboard of registers with an outstanding secondary write, so the hazard logic can stall dependent instructions.
- Sits between the writeback mux, the multicycle unit and the register file.

Parameters:
- MAX_WAIT, 4: consecutive cycles the secondary may be denied before the core is force-stalled (legal range 1..15).
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- core_we  in  1  core writeback enable
- core_a3  in  5  core destination register
- core_wd  in  32  core write data
- sec_valid  in  1  secondary write request valid
- sec_ready  out  1  secondary request accepted this cycle
- sec_a3  in  5  secondary destination register
- sec_wd  in  32  secondary write data
- iss_valid  in  1  secondary op issued (reserve its destination)
- iss_rd  in  5  destination register of the issued op
- stall_core  out  1  core must hold PC/instruction this cycle
- busy  out  32  scoreboard; bit i=1 means x_i has a pending secondary write
- rf_we  out  1  to register file WE
- rf_a3  out  5  to register file A3
- rf_wd  out  32  to register file WD3

Behaviour:
- State held in registers: busy[31:0] and wait_cnt[CNT_W-1:0]. All grant and port outputs are combinational from this state and the inputs.
- Reset: while reset=1 the next state is busy=0 and wait_cnt=0. All outputs are forced to rf_we=0, sec_ready=0, stall_core=0, rf_a3=0, rf_wd=0. Reset overrides any request in the same cycle; nothing is committed and the scoreboard clears.
- core_use = core_we && core_a3!=0. A core write to x0 does not occupy the port.
- force = (wait_cnt==MAX_WAIT) && sec_valid.
- Grant rules:
  - If force=1: stall_core=1, core write suppressed, secondary granted. The core re-presents its write next cycle.
  - Else if core_use=1: rf_we=1, rf_a3=core_a3, rf_wd=core_wd, sec_ready=0.
  - Else if sec_valid=1: sec_ready=1. rf_we = (sec_a3!=0), rf_a3=sec_a3, rf_wd=sec_wd.
  - Else: rf_we=0, rf_a3=0, rf_wd=0.
- Secondary writes to x0: accepted (sec_ready=1) and consumed without asserting rf_we.
- A secondary handshake completes on a posedge where sec_valid && sec_ready. The secondary must keep sec_a3/sec_wd stable until then.
- Latency: a granted write lands in the register file on the same rising edge; there is zero added latency.
- Wait counter:
  - Clears to 0 on any handshake, or whenever sec_valid=0.
  - Otherwise increments while sec_valid && !sec_ready.
  - Saturates at MAX_WAIT.
  - Consequence: at most MAX_WAIT consecutive denials, then a forced grant.
- Scoreboard:
  - Set busy[iss_rd] on iss_valid && iss_rd!=0.
  - Clear busy[sec_a3] on a secondary handshake.
  - Same register set and cleared in the same cycle: set wins (a new op is outstanding).
  - busy[0] is always 0.
  - Issuing to an already-busy register keeps the bit at 1. The hazard unit must prevent this; the block does not flag it.
- The block does not resolve WAW hazards between the core and a pending secondary write. It only exposes busy.

Decomposition:
- Shared package rv_pkg:
  - REG_X0 = 5'd0
  - XLEN = 32
  - NREGS = 32
  - typedef reg_addr_t (5 bits)
  - typedef xword_t (32 bits)
- One natural sub-module: reg_scoreboard, holding busy[31:0] with set/clear ports and the set-wins rule. The arbiter and wait counter stay in the top module.

Test Plan:
- Reset: hold reset with core_we=1, sec_valid=1 and busy pre-filled by issues, then release → busy=0, rf_we=0 during reset, and the first post-reset cycle grants the core.
- Core only: core_we=1, core_a3=5, core_wd=0xDEADBEEF → rf_we=1, rf_a3=5, sec_ready=0. The same write with core_a3=0 and sec_valid=1, sec_a3=7, sec_wd=0x11 → secondary granted, rf_a3=7.
- Starvation, MAX_WAIT=4: core_use held high and sec_valid=1 continuously → sec_ready=0 for 4 cycles. On the 5th cycle stall_core=1, sec_ready=1 and rf_wd=secondary data. The next cycle shows the core write, with wait_cnt=0.
- Scoreboard: iss_valid with iss_rd=9 → busy[9]=1 next cycle. Secondary handshake with sec_a3=9 → busy[9]=0. Issue rd=9 together with a commit to 9 in the same cycle → busy[9] stays 1.
- x0 handling: iss_rd=0 → busy unchanged. Secondary sec_a3=0 with the port idle → sec_ready=1, rf_we=0, wait_cnt=0.
- Mid-request reset: secondary waiting with wait_cnt=3, assert reset for one cycle → wait_cnt=0. After release, 4 more denials are required before the next forced stall.
